// File: rtl/lfsr_az_pkg.sv
// Shared constants for the add-zero Fibonacci LFSR (full 2^WIDTH period).
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package lfsr_az_pkg;

  localparam int WIDTH_MIN = 3;
  localparam int WIDTH_MAX = 16;

  // Maximal-length Fibonacci tap masks, indexed by register width.
  // Bit k set means state bit k feeds the XOR; bit WIDTH-1 is always set.
  // Entries 0..2 are unused placeholders so the index equals the width.
  localparam logic [WIDTH_MAX:0][15:0] TAPS_TBL = {
    16'hD008,  // 16: taps 16,15,13,4
    16'h6000,  // 15: taps 15,14
    16'h2015,  // 14: taps 14,5,3,1
    16'h100D,  // 13: taps 13,4,3,1
    16'h0829,  // 12: taps 12,6,4,1
    16'h0500,  // 11: taps 11,9
    16'h0240,  // 10: taps 10,7
    16'h0110,  //  9: taps 9,5
    16'h00B8,  //  8: taps 8,6,5,4
    16'h0060,  //  7: taps 7,6
    16'h0030,  //  6: taps 6,5
    16'h0014,  //  5: taps 5,3
    16'h000C,  //  4: taps 4,3
    16'h0006,  //  3: taps 3,2
    16'h0000,  //  2: unused
    16'h0000,  //  1: unused
    16'h0000   //  0: unused
  };

  // Per-cycle action of a generator; restart outranks enable.
  typedef enum logic [1:0] {
    ACT_HOLD = 2'd0,
    ACT_STEP = 2'd1,
    ACT_LOAD = 2'd2
  } step_e;

endpackage : lfsr_az_pkg

// File: rtl/lfsr_az_core.sv
// One add-zero Fibonacci LFSR channel: visits all 2^WIDTH states, zero included.
// Latency: data is registered; a step or reload is visible one clock later.
// Backpressure: none; enable low holds state, restart reloads from seed.
module lfsr_az_core
  import lfsr_az_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = TAPS_TBL[WIDTH][WIDTH-1:0]
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] seed,
  input  logic             enable,
  input  logic             restart,
  output logic [WIDTH-1:0] data
);

  logic [WIDTH-1:0] r_state;
  logic [WIDTH-1:0] w_next;
  logic             w_fb;
  logic             w_low_zero;
  step_e            w_act;

  // Resolve the cycle's action: reload beats step beats hold.
  always_comb begin
    w_act = ACT_HOLD;
    if (restart) begin
      w_act = ACT_LOAD;
    end else if (enable) begin
      w_act = ACT_STEP;
    end
  end

  // The extra term flips feedback when all bits below the MSB are zero.
  // That splices state 0 between 10..0 and 0..01, lengthening the
  // maximal 2^WIDTH-1 cycle by exactly the all-zero state.
  assign w_low_zero = (r_state[WIDTH-2:0] == '0);
  assign w_fb       = (^(r_state & TAPS)) ^ w_low_zero;

  // Next-state selection for the chosen action.
  always_comb begin
    w_next = r_state;
    unique case (w_act)
      ACT_LOAD: w_next = seed;
      ACT_STEP: w_next = {r_state[WIDTH-2:0], w_fb};
      default:  w_next = r_state;
    endcase
  end

  // State register; reset clears to zero rather than loading seed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= '0;
    end else begin
      r_state <= w_next;
    end
  end

  assign data = r_state;

endmodule : lfsr_az_core

// File: rtl/lfsr_az_param.sv
// CHANNELS lockstep add-zero LFSRs with optional period tracking (LFSR_PERIOD_FLAG_EN).
// Latency: data/wrap/done registered, one clock after the controlling edge.
// Backpressure: none; enable low freezes data and period counter.
module lfsr_az_param
  import lfsr_az_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] TAPS     = TAPS_TBL[WIDTH][WIDTH-1:0],
  parameter int               CHANNELS = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] seed,
  input  logic                      enable,
  input  logic                      restart,
  output logic [CHANNELS*WIDTH-1:0] data,
  output logic                      wrap,
  output logic                      done
);

  // Reject configurations the tap table and channel packing cannot serve.
  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("lfsr_az_param: WIDTH out of range 3..16");
  end
  if (CHANNELS < 1 || CHANNELS > 8) begin : g_bad_channels
    $error("lfsr_az_param: CHANNELS out of range 1..8");
  end
  if (TAPS[WIDTH-1] != 1'b1) begin : g_bad_taps
    $error("lfsr_az_param: TAPS must have bit WIDTH-1 set");
  end

  // All channels share enable/restart so they step in lockstep.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    lfsr_az_core #(
      .WIDTH (WIDTH),
      .TAPS  (TAPS)
    ) u_core (
      .clk     (clk),
      .reset   (reset),
      .seed    (seed[c*WIDTH +: WIDTH]),
      .enable  (enable),
      .restart (restart),
      .data    (data[c*WIDTH +: WIDTH])
    );
  end

`ifdef LFSR_PERIOD_FLAG_EN
  // The counter tracks steps since the last reload modulo 2^WIDTH; since
  // the period is exactly 2^WIDTH, its wrap coincides with data returning
  // to the reload value on every channel at once.
  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_cnt;
  logic             r_wrap;
  logic             r_done;
  logic             w_cnt_last;

  assign w_cnt_last = (r_cnt == {WIDTH{1'b1}});

  // Period counter and flags; restart clears all, even on a wrapping step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt  <= '0;
      r_wrap <= 1'b0;
      r_done <= 1'b0;
    end else if (restart) begin
      r_cnt  <= '0;
      r_wrap <= 1'b0;
      r_done <= 1'b0;
    end else if (enable) begin
      r_cnt  <= r_cnt + CNT_ONE;
      r_wrap <= w_cnt_last;
      if (w_cnt_last) begin
        r_done <= 1'b1;
      end
    end else begin
      r_wrap <= 1'b0;
    end
  end

  assign wrap = r_wrap;
  assign done = r_done;
`else
  // Period tracking not built: flags are kept as ports but held low.
  assign wrap = 1'b0;
  assign done = 1'b0;
`endif

endmodule : lfsr_az_param

// File: tb/tb_lfsr_az_param.sv
// Bench for lfsr_az_param: WIDTH=4 single channel and WIDTH=8 two-channel instances.
// Inputs driven on the falling edge, outputs compared on the following falling edge.
// Expected values come from a step-count model built from the add-zero feedback rule.
module tb_lfsr_az_param;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: WIDTH=4, one channel
  logic        a_rst, a_en, a_rs;
  logic [3:0]  a_seed;
  logic [3:0]  a_data;
  logic        a_wrap, a_done;

  // Instance B: WIDTH=8, two channels
  logic        b_rst, b_en, b_rs;
  logic [15:0] b_seed;
  logic [15:0] b_data;
  logic        b_wrap, b_done;

  lfsr_az_param #(.WIDTH(4)) u_a (
    .clk(clk), .reset(a_rst), .seed(a_seed), .enable(a_en), .restart(a_rs),
    .data(a_data), .wrap(a_wrap), .done(a_done)
  );

  lfsr_az_param #(.WIDTH(8), .CHANNELS(2)) u_b (
    .clk(clk), .reset(b_rst), .seed(b_seed), .enable(b_en), .restart(b_rs),
    .data(b_data), .wrap(b_wrap), .done(b_done)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Flags only exist when period tracking is built in.
  function automatic bit flag(input bit v);
`ifdef LFSR_PERIOD_FLAG_EN
    return v;
`else
    return v & 1'b0;
`endif
  endfunction

  // Spec rule: shift left, feedback = parity(state & taps) XOR (low bits all zero).
  function automatic int unsigned lfsr_step(input int unsigned s, input int w, input int unsigned taps);
    int unsigned mask;
    bit fb;
    mask = (32'd1 << w) - 1;
    fb   = ($countones(s & taps) % 2) == 1;
    if ((s & (mask >> 1)) == 0) fb = !fb;
    return ((s << 1) | fb) & mask;
  endfunction

  // Reference state: values, steps since last reload, flags.
  int unsigned ma_data;
  int          ma_steps;
  bit          ma_wrap, ma_done;
  int unsigned mb_data [2];
  int          mb_steps;
  bit          mb_wrap, mb_done;

  task automatic a_cycle(input bit en, input bit rs, input logic [3:0] sd, input string tag);
    a_en = en; a_rs = rs; a_seed = sd;
    @(posedge clk);
    if (rs) begin
      ma_data = sd; ma_steps = 0; ma_wrap = 0; ma_done = 0;
    end else if (en) begin
      ma_data  = lfsr_step(ma_data, 4, 32'hC);
      ma_steps = ma_steps + 1;
      ma_wrap  = (ma_steps % 16) == 0;
      ma_done  = ma_done | ma_wrap;
    end else begin
      ma_wrap = 0;
    end
    @(negedge clk);
    chk({tag, "_data"}, a_data, ma_data);
    chk({tag, "_wrap"}, a_wrap, flag(ma_wrap));
    chk({tag, "_done"}, a_done, flag(ma_done));
  endtask

  task automatic b_cycle(input bit en, input bit rs, input logic [15:0] sd, input string tag);
    b_en = en; b_rs = rs; b_seed = sd;
    @(posedge clk);
    if (rs) begin
      mb_data[0] = sd[7:0]; mb_data[1] = sd[15:8];
      mb_steps = 0; mb_wrap = 0; mb_done = 0;
    end else if (en) begin
      for (int c = 0; c < 2; c++) mb_data[c] = lfsr_step(mb_data[c], 8, 32'hB8);
      mb_steps = mb_steps + 1;
      mb_wrap  = (mb_steps % 256) == 0;
      mb_done  = mb_done | mb_wrap;
    end else begin
      mb_wrap = 0;
    end
    @(negedge clk);
    chk({tag, "_ch0"},  b_data[7:0],  mb_data[0]);
    chk({tag, "_ch1"},  b_data[15:8], mb_data[1]);
    chk({tag, "_wrap"}, b_wrap, flag(mb_wrap));
    chk({tag, "_done"}, b_done, flag(mb_done));
  endtask

  logic [3:0] seq4 [17];
  bit         seen [256];
  int         wraps, distinct;
  logic [3:0] frozen;

  initial begin
    seq4 = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1001, 4'b0011, 4'b0110, 4'b1101,
             4'b1010, 4'b0101, 4'b1011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
    a_rst = 1'b1; a_en = 1'b0; a_rs = 1'b0; a_seed = 4'hF;
    b_rst = 1'b1; b_en = 1'b0; b_rs = 1'b0; b_seed = 16'hFFFF;
    ma_data = 0; ma_steps = 0; ma_wrap = 0; ma_done = 0;
    mb_data[0] = 0; mb_data[1] = 0; mb_steps = 0; mb_wrap = 0; mb_done = 0;

    // Reset asserted before any clock edge: outputs clear asynchronously.
    #2 a_rst = 1'b0; b_rst = 1'b0;
    #1;
    chk("rst_a_data", a_data, 0);
    chk("rst_a_wrap", a_wrap, 0);
    chk("rst_a_done", a_done, 0);
    chk("rst_b_data", b_data, 0);

    // Enable and restart under reset have no effect; seed is not loaded.
    a_en = 1'b1; a_rs = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_hold_a", a_data, 0);
    a_rs = 1'b0;
    a_rst = 1'b1; b_rst = 1'b1;

    // Width-4 full-period sequence straight out of reset.
    wraps = 0;
    for (int i = 1; i <= 16; i++) begin
      a_cycle(1'b1, 1'b0, 4'($urandom), "seq4");
      chk("seq4_tbl", a_data, seq4[i]);
      if (a_wrap) wraps++;
    end
    chk("seq4_wraps", wraps, flag(1'b1));
    a_cycle(1'b1, 1'b0, 4'h0, "seq4_after");

    // Restart colliding with the wrapping step: restart wins.
    a_cycle(1'b0, 1'b1, 4'h3, "rsw_load");
    for (int i = 0; i < 15; i++) a_cycle(1'b1, 1'b0, 4'($urandom), "rsw_run");
    a_cycle(1'b1, 1'b1, 4'h7, "rsw_hit");
    chk("rsw_data", a_data, 4'h7);
    chk("rsw_nowrap", a_wrap, 0);

    // Random mix of enable, restart and seed noise.
    for (int i = 0; i < 150; i++)
      a_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, 4'($urandom), "rnd_a");

    // Freeze for five cycles while seed wiggles.
    for (int i = 0; i < 7; i++) a_cycle(1'b1, 1'b0, 4'($urandom), "frz_pre");
    frozen = a_data;
    for (int i = 0; i < 5; i++) begin
      a_cycle(1'b0, 1'b0, 4'($urandom), "frz");
      chk("frz_equal", a_data, frozen);
    end

    // Restart with 1001 (enable state irrelevant), wrap lands on step 16.
    a_cycle(1'($urandom), 1'b1, 4'b1001, "r1001");
    chk("r1001_data", a_data, 4'b1001);
    chk("r1001_done", a_done, 0);
    for (int i = 1; i <= 16; i++) begin
      a_cycle(1'b1, 1'b0, 4'($urandom), "r1001_run");
      chk("r1001_wrap16", a_wrap, flag(i == 16));
    end
    chk("r1001_back", a_data, 4'b1001);
    for (int i = 0; i < 3; i++) a_cycle(1'b1, 1'b0, 4'($urandom), "pre_arst");

    // Reset pulled low between edges: clears immediately.
    #2 a_rst = 1'b0;
    #1;
    chk("arst_data", a_data, 0);
    chk("arst_done", a_done, 0);
    chk("arst_wrap", a_wrap, 0);
    ma_data = 0; ma_steps = 0; ma_wrap = 0; ma_done = 0;
    @(negedge clk);
    a_rst = 1'b1;
    a_cycle(1'b1, 1'b0, 4'hA, "arst_first");
    chk("arst_0001", a_data, 4'b0001);

    // Two channels, seeds 00 and 5A, one full 256-step period.
    b_cycle(1'b0, 1'b1, {8'h5A, 8'h00}, "b_load");
    wraps = 0; distinct = 0;
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    for (int i = 0; i < 256; i++) begin
      b_cycle(1'b1, 1'b0, 16'($urandom), "b_per");
      if (!seen[b_data[7:0]]) distinct++;
      seen[b_data[7:0]] = 1'b1;
      if (b_wrap) wraps++;
    end
    chk("b_distinct", distinct, 256);
    chk("b_wraps", wraps, flag(1'b1));
    for (int i = 0; i < 20; i++) b_cycle(1'b1, 1'b0, 16'($urandom), "b_post");
    chk("b_done_sticky", b_done, flag(1'b1));

    // Random traffic on the two-channel instance.
    for (int i = 0; i < 200; i++)
      b_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0, 16'($urandom), "rnd_b");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_lfsr_az_param
